fixed_point_divider: RTL

- Sequential non-restoring divider, the inverse operation to the fixed-point multiplier datapath.
- Computes quotient = (dividend << FRAC_BITS) / divisor, unsigned, one quotient bit per clock.
- Uses a single WIDTH+1-bit add/subtract stage per iteration, with the subtract-select XOR'ed into the divisor and carry-in.
- Sits beside the multiplier as the divide unit for Q(WIDTH-FRAC_BITS).FRAC_BITS operands, with a start/done handshake.

---
 rtl/fixed_point_divider.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fixed_point_divider.sv
// Sequential non-restoring unsigned divider for Q(WIDTH-FRAC_BITS).FRAC_BITS operands.
// Produces quotient = (dividend << FRAC_BITS) / divisor, one quotient bit per clock.
module fixed_point_divider #(
    parameter int WIDTH     = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int ITER = WIDTH + FRAC_BITS;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

    state_t           state, state_next;
    logic [WIDTH:0]   p, p_shift, p_step;
    logic [WIDTH-1:0] p_fix;
    logic [WIDTH-1:0] d;
    logic [ITER-1:0]  n, q;
    logic [CW-1:0]    cnt;
    logic             sub, q_bit, last_iter;
    logic [WIDTH-1:0] q_sat;
    logic             q_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign last_iter = (cnt == CW'(ITER - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (divisor == '0) ? ZERO : RUN;
            RUN:  if (last_iter) state_next = FIX;
            FIX:  state_next = IDLE;
            ZERO: if (cnt != '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One add/subtract stage: the subtract select inverts the divisor and supplies the carry-in.
    always_comb begin
        sub     = ~p[WIDTH];
        p_shift = {p[WIDTH-1:0], n[ITER-1]};
        p_step  = p_shift + ({1'b0, d} ^ {(WIDTH + 1){sub}}) + {{WIDTH{1'b0}}, sub};
        q_bit   = ~p_step[WIDTH];
        p_fix   = p[WIDTH] ? (p[WIDTH-1:0] + d) : p[WIDTH-1:0];
    end

    always_comb begin
        q_ovf = (q[ITER-1:WIDTH] != '0);
        q_sat = q_ovf ? '1 : q[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p           <= '0;
            n           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        d           <= divisor;
                        n           <= {dividend, {FRAC_BITS{1'b0}}};
                        p           <= '0;
                        q           <= '0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    p   <= p_step;
                    n   <= n << 1;
                    q   <= {q[ITER-2:0], q_bit};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    remainder <= p_fix;
                    quotient  <= q_sat;
                    overflow  <= q_ovf;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                ZERO: begin
                    // Finalises on its second edge; the captured dividend still sits in the top of n.
                    cnt <= cnt + CW'(1);
                    if (cnt != '0) begin
                        quotient    <= '1;
                        remainder   <= n[ITER-1 -: WIDTH];
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
